// File: rtl/clasificador_entrada.sv
// clasificador_entrada: one-word holding register that steers each word to the FIFO
// selected by its top class bits. Define CLASIFICADOR_ENTRADA_DROP_EN to drop words aimed at a full FIFO.
module clasificador_entrada #(
  parameter int QUEUE_QUANTITY = 4,
  parameter int DATA_BITS      = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enb,
  input  logic                      in_valid,
  input  logic [DATA_BITS-1:0]      in_data,
  output logic                      in_ready,
  input  logic [QUEUE_QUANTITY-1:0] fifo_full,
  output logic [QUEUE_QUANTITY-1:0] push,
  output logic [DATA_BITS-1:0]      push_data,
  output logic                      bloqueado,
  output logic [15:0]               contador_total,
  output logic [7:0]                drop_count
);

  localparam int CLS_W = $clog2(QUEUE_QUANTITY);

  typedef enum logic [1:0] {VACIO, CARGADO, BLOQUEADO} state_t;

  state_t               state, state_nxt;
  logic [DATA_BITS-1:0] held_data;
  logic [CLS_W-1:0]     held_cls;
  logic [CLS_W-1:0]     in_cls;
  logic                 held_valid;
  logic                 active;
  logic                 target_full;
  logic                 push_fire;
  logic                 leave;
  logic                 accept;
  logic                 full_blocks;

  assign in_cls      = in_data[DATA_BITS-1 -: CLS_W];
  assign active      = enb && !rst;
  assign held_valid  = (state != VACIO);
  assign target_full = fifo_full[held_cls];
  assign push_fire   = active && held_valid && !target_full;
  assign accept      = in_valid && in_ready;
  assign push_data   = held_valid ? held_data : '0;

`ifdef CLASIFICADOR_ENTRADA_DROP_EN
  // A held word aimed at a full FIFO leaves the register anyway, so input is never stalled.
  logic drop_fire;
  assign drop_fire   = active && held_valid && target_full;
  assign leave       = push_fire || drop_fire;
  assign in_ready    = active;
  assign bloqueado   = 1'b0;
  assign full_blocks = 1'b0;
`else
  assign leave       = push_fire;
  assign in_ready    = active && (!held_valid || !target_full);
  assign bloqueado   = held_valid && target_full;
  assign full_blocks = 1'b1;
`endif

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    push = '0;
    if (push_fire) push[held_cls] = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    if (leave || !held_valid) begin
      if (accept) state_nxt = (full_blocks && fifo_full[in_cls]) ? BLOQUEADO : CARGADO;
      else        state_nxt = VACIO;
    end else begin
      state_nxt = (full_blocks && target_full) ? BLOQUEADO : CARGADO;
    end
  end

  // Reset wins over enb; with enb low every register holds.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state          <= VACIO;
      held_data      <= '0;
      held_cls       <= '0;
      contador_total <= '0;
    end else if (enb) begin
      state <= state_nxt;
      if (accept) begin
        held_data <= in_data;
        held_cls  <= in_cls;
      end
      if (push_fire) contador_total <= contador_total + 16'd1;
    end
  end

`ifdef CLASIFICADOR_ENTRADA_DROP_EN
  always_ff @(posedge clk) begin
    if (rst)                                  drop_count <= '0;
    else if (drop_fire && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
  end
`else
  assign drop_count = '0;
`endif

endmodule

// File: doc/clasificador_entrada.md
CLASIFICADOR_ENTRADA -- requirements
Module: clasificador_entrada

Interface
REQ-001 Parameter QUEUE_QUANTITY, default 4, SHALL set the number of destination FIFOs (power of two, at least 2).
REQ-002 Parameter DATA_BITS, default 8, SHALL set the word width; the class field SHALL be in_data[DATA_BITS-1 -: $clog2(QUEUE_QUANTITY)].
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the synchronous, active-high reset.
REQ-005 Port enb, input, 1, SHALL be the global enable; while low, all state is frozen.
REQ-006 Port in_valid, input, 1, SHALL flag a word on in_data.
REQ-007 Port in_data, input, DATA_BITS, SHALL carry the incoming word, including its class bits.
REQ-008 Port in_ready, output, 1, SHALL flag that the block accepts in_data this cycle.
REQ-009 Port fifo_full, input, QUEUE_QUANTITY, SHALL carry one full flag per destination FIFO.
REQ-010 Port push, output, QUEUE_QUANTITY, SHALL carry one-hot write strobes, one per FIFO.
REQ-011 Port push_data, output, DATA_BITS, SHALL carry the word being written.
REQ-012 Port bloqueado, output, 1, SHALL be high while a held word waits on a full FIFO.
REQ-013 Port contador_total, output, 16, SHALL count words pushed since reset.
REQ-014 Port drop_count, output, 8, SHALL count discarded words (see REQ-030).

Function
REQ-015 A word SHALL be accepted when in_valid && in_ready at a rising edge; it is stored in a one-word holding register (data, class, valid).
REQ-016 FSM states SHALL be VACIO (register empty), CARGADO (word held, target not full) and BLOQUEADO (word held, target full).
REQ-017 in_ready SHALL equal enb && !rst && (state==VACIO || !fifo_full[held class]), so full throughput is one word per cycle.
REQ-018 push[c] SHALL be asserted combinationally when enb && !rst && the register is valid && its class is c && !fifo_full[c]; all other push bits SHALL be 0.
REQ-019 push_data SHALL equal the held data at all times, and SHALL be 0 when the register is empty.
REQ-020 Latency SHALL be exactly 1 cycle from acceptance to push when the target FIFO is not full.
REQ-021 On push with simultaneous acceptance, the register SHALL load the new word and the state SHALL become CARGADO or BLOQUEADO per the new word's target.
REQ-022 On push without acceptance, the state SHALL go to VACIO.
REQ-023 A held word whose target is full SHALL put the state in BLOQUEADO and drive bloqueado=1; it SHALL be pushed in the first cycle that its target's fifo_full is low.
REQ-024 fifo_full of non-target FIFOs SHALL have no effect; ordering SHALL be strict (no bypass of a blocked word).
REQ-025 contador_total SHALL increment by 1 per push cycle and wrap from 16'hFFFF to 0.
REQ-026 With enb low, push SHALL be 0, in_ready SHALL be 0, and the register, state and counters SHALL hold.

Reset
REQ-027 While rst is high, push SHALL be 0 and in_ready SHALL be 0, and any held word SHALL be discarded without a push or a drop count.
REQ-028 After reset the state SHALL be VACIO, with bloqueado=0, push_data=0, contador_total=0 and drop_count=0; reset SHALL override enb.

Configuration
REQ-029 Macro CLASIFICADOR_ENTRADA_DROP_EN SHALL select the full-target policy.
REQ-030 With CLASIFICADOR_ENTRADA_DROP_EN defined, a held word whose target is full SHALL be discarded at the next edge, increment drop_count (saturating at 8'hFF) and never enter BLOQUEADO, so bloqueado stays 0; in_ready SHALL then equal enb && !rst.
REQ-031 With CLASIFICADOR_ENTRADA_DROP_EN not defined, the block SHALL apply backpressure per REQ-023 and drop_count SHALL be tied to 0.

Verification (QUEUE_QUANTITY=4, DATA_BITS=8, class = bits [7:6])
REQ-032 Reset, then in_data=8'h41 valid for 1 cycle -> next cycle push=4'b0010, push_data=8'h41, contador_total=1, in_ready=1 throughout.
REQ-033 Back-to-back 8'h00, 8'hC0, 8'h80 -> pushes 4'b0001, 4'b1000, 4'b0100 on 3 consecutive cycles, with no in_ready deassertion.
REQ-034 No macro: fifo_full=4'b0100, send 8'h85, then 8'h12, and clear fifo_full after 3 cycles -> bloqueado=1 and in_ready=0 for 3 cycles, then push=4'b0100 with data 8'h85, followed by push=4'b0001 with data 8'h12.
REQ-035 Macro defined: same stimulus as REQ-034 -> no push for 8'h85, drop_count=1, bloqueado=0, and 8'h12 pushed 1 cycle after its acceptance.
REQ-036 rst asserted for 1 cycle while in BLOQUEADO -> push=0 that cycle; afterwards state VACIO, contador_total=0, and in_ready=1 with enb=1.
REQ-037 enb low for 2 cycles with 8'h41 held -> push=0 and in_ready=0 during those cycles; push=4'b0010 in the first cycle enb returns high.
